// File: rtl/sprite_line_mapper_pkg.sv
// Shared types and helpers for the scanline sprite mapper.
// Holds the per-line list entry, the empty-slot ID, the scan FSM states and
// the 1-bit-wider window test used by both the Y scan and the X pixel match.
package sprite_pkg;

   localparam int COORD_W   = 10;
   localparam int ID_W      = 4;
   localparam int SIZE_LOG2 = 5;

   // An all-ones ID marks an unused sprite slot and is also the "no sprite" output.
   localparam logic [ID_W-1:0] EMPTY_ID = {ID_W{1'b1}};

   typedef struct packed {
      logic [COORD_W-1:0]   PosX;
      logic [ID_W-1:0]      ID;
      logic [SIZE_LOG2-1:0] yoff;
   } line_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // True when pos <= coord < pos + 2**size_log2. The extra top bit keeps a
   // sprite near the top of the coordinate range from wrapping back to 0.
   function automatic logic in_range(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] coord,
                                     input int                 size_log2);
      logic [COORD_W:0] lo;
      logic [COORD_W:0] hi;
      logic [COORD_W:0] c;
      lo = {1'b0, pos};
      c  = {1'b0, coord};
      hi = lo + ((COORD_W+1)'(1) << size_log2);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/sprite_line_mapper_if.sv
// Bus between the sprite register file / VGA timing and the line mapper.
// slave  : the mapper side (takes line timing, pixel X and sprite table; returns lookup result)
// master : the driving side
interface sprite_line_mapper_if
   import sprite_pkg::*;
   #(parameter int NUM_SPRITES = 16) ();

   logic                          line_start;
   logic [COORD_W-1:0]            line_y;
   logic [COORD_W-1:0]            DrawX;
   logic [NUM_SPRITES*COORD_W-1:0] PosX;
   logic [NUM_SPRITES*COORD_W-1:0] PosY;
   logic [NUM_SPRITES*ID_W-1:0]   SpriteID;
   logic [ID_W-1:0]               spriteIDOut;
   logic [SIZE_LOG2-1:0]          sPosXOut;
   logic [SIZE_LOG2-1:0]          sPosYOut;
   logic                          hit;
   logic                          overflow;
   logic                          scan_busy;

   modport slave (
      input  line_start, line_y, DrawX, PosX, PosY, SpriteID,
      output spriteIDOut, sPosXOut, sPosYOut, hit, overflow, scan_busy
   );

   modport master (
      output line_start, line_y, DrawX, PosX, PosY, SpriteID,
      input  spriteIDOut, sPosXOut, sPosYOut, hit, overflow, scan_busy
   );

endinterface

// File: rtl/sprite_line_mapper_pixel_select.sv
// Combinational priority match of the current pixel X against the active line list.
// Ports:
//   entries   in  active line list (entry 0 = lowest slot number)
//   count     in  number of valid entries
//   DrawX     in  current pixel X
//   match     out some valid entry covers DrawX
//   matchId   out ID of the lowest matching entry, EMPTY_ID if none
//   matchXOff out DrawX minus that entry's X, 0 if none
//   matchYOff out that entry's stored Y offset, 0 if none
module sprite_pixel_select
   import sprite_pkg::*;
   #(parameter int MAX_PER_LINE = 8,
     parameter int CNT_W        = 4)
   (input  line_entry_t [MAX_PER_LINE-1:0] entries,
    input  logic [CNT_W-1:0]               count,
    input  logic [COORD_W-1:0]             DrawX,
    output logic                           match,
    output logic [ID_W-1:0]                matchId,
    output logic [SIZE_LOG2-1:0]           matchXOff,
    output logic [SIZE_LOG2-1:0]           matchYOff);

   localparam int LAW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

   logic [MAX_PER_LINE-1:0] hitVec;
   logic [LAW-1:0]          selIdx;
   logic [COORD_W-1:0]      xDiff;

   // Per-entry window test, then pick the lowest index by walking downward.
   always_comb begin
      hitVec = '0;
      selIdx = '0;
      for (int k = MAX_PER_LINE - 1; k >= 0; k--) begin
         hitVec[k] = (CNT_W'(k) < count) && in_range(entries[k].PosX, DrawX, SIZE_LOG2);
         selIdx    = hitVec[k] ? LAW'(k) : selIdx;
      end
   end

   // Result fields for the selected entry, forced to the idle values on a miss.
   always_comb begin
      xDiff = DrawX - entries[selIdx].PosX;
      match = |hitVec;
      if (match) begin
         matchId   = entries[selIdx].ID;
         matchXOff = xDiff[SIZE_LOG2-1:0];
         matchYOff = entries[selIdx].yoff;
      end else begin
         matchId   = EMPTY_ID;
         matchXOff = {SIZE_LOG2{1'b0}};
         matchYOff = {SIZE_LOG2{1'b0}};
      end
   end

endmodule

// File: rtl/sprite_line_mapper.sv
// Scanline sprite mapper. While one line is displayed, all sprite slots are
// scanned (one per clock) to build the list of sprites visible on line_y; the
// list is swapped in on line_start so the pixel lookup only compares against
// MAX_PER_LINE entries.
// Ports:
//   Clk    in  system clock
//   Reset  in  asynchronous active-high reset
//   bus    slave side of sprite_line_mapper_if:
//          line_start/line_y/DrawX/PosX/PosY/SpriteID in,
//          spriteIDOut/sPosXOut/sPosYOut/hit/overflow/scan_busy out (all registered)
module sprite_line_mapper
   import sprite_pkg::*;
   #(parameter int NUM_SPRITES  = 16,
     parameter int MAX_PER_LINE = 8)
   (input logic Clk,
    input logic Reset,
    sprite_line_mapper_if.slave bus);

   localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
   localparam int LAW   = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

   state_t                          state;
   logic [IDX_W-1:0]                slotIdx;
   logic [COORD_W-1:0]              ly;
   line_entry_t [MAX_PER_LINE-1:0]  scanList;
   line_entry_t [MAX_PER_LINE-1:0]  activeList;
   logic [CNT_W-1:0]                scanCount;
   logic [CNT_W-1:0]                activeCount;
   logic                            scanOvf;
   logic                            activeOvf;
   logic                            scanBusy;

   logic [COORD_W-1:0]              slotPosX;
   logic [COORD_W-1:0]              slotPosY;
   logic [COORD_W-1:0]              slotYDiff;
   logic [ID_W-1:0]                 slotId;
   logic                            slotSel;
   line_entry_t                     newEntry;

   logic                            pixHit;
   logic [ID_W-1:0]                 pixId;
   logic [SIZE_LOG2-1:0]            pixXOff;
   logic [SIZE_LOG2-1:0]            pixYOff;

   logic                            hitR;
   logic [ID_W-1:0]                 idOutR;
   logic [SIZE_LOG2-1:0]            xOutR;
   logic [SIZE_LOG2-1:0]            yOutR;

   // Decode the slot currently being scanned and decide whether it lands on line ly.
   always_comb begin
      slotPosX      = bus.PosX[slotIdx*COORD_W +: COORD_W];
      slotPosY      = bus.PosY[slotIdx*COORD_W +: COORD_W];
      slotId        = bus.SpriteID[slotIdx*ID_W +: ID_W];
      slotYDiff     = ly - slotPosY;
      slotSel       = (slotId != EMPTY_ID) && in_range(slotPosY, ly, SIZE_LOG2);
      newEntry.PosX = slotPosX;
      newEntry.ID   = slotId;
      newEntry.yoff = slotYDiff[SIZE_LOG2-1:0];
   end

   // Scan FSM plus list double-buffer; line_start always wins and restarts the scan.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         slotIdx     <= {IDX_W{1'b0}};
         ly          <= {COORD_W{1'b0}};
         scanList    <= '0;
         activeList  <= '0;
         scanCount   <= {CNT_W{1'b0}};
         activeCount <= {CNT_W{1'b0}};
         scanOvf     <= 1'b0;
         activeOvf   <= 1'b0;
         scanBusy    <= 1'b0;
      end else if (bus.line_start) begin
         // A scan cut short still hands over what it found, but flags the line.
         activeList  <= scanList;
         activeCount <= scanCount;
         activeOvf   <= scanOvf | (state == SCAN);
         scanCount   <= {CNT_W{1'b0}};
         scanOvf     <= 1'b0;
         ly          <= bus.line_y;
         slotIdx     <= {IDX_W{1'b0}};
         state       <= SCAN;
         scanBusy    <= 1'b1;
      end else begin
         case (state)
            SCAN: begin
               if (slotSel) begin
                  if (scanCount < CNT_W'(MAX_PER_LINE)) begin
                     scanList[scanCount[LAW-1:0]] <= newEntry;
                     scanCount                    <= scanCount + CNT_W'(1);
                  end else begin
                     scanOvf <= 1'b1;
                  end
               end else begin
                  scanOvf <= scanOvf;
               end
               if (slotIdx == IDX_W'(NUM_SPRITES - 1)) begin
                  slotIdx  <= {IDX_W{1'b0}};
                  state    <= DONE;
                  scanBusy <= 1'b0;
               end else begin
                  slotIdx <= slotIdx + IDX_W'(1);
               end
            end
            IDLE, DONE: begin
               scanBusy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               scanBusy <= 1'b0;
            end
         endcase
      end
   end

   sprite_pixel_select #(
      .MAX_PER_LINE (MAX_PER_LINE),
      .CNT_W        (CNT_W)
   ) u_pixel_select (
      .entries   (activeList),
      .count     (activeCount),
      .DrawX     (bus.DrawX),
      .match     (pixHit),
      .matchId   (pixId),
      .matchXOff (pixXOff),
      .matchYOff (pixYOff)
   );

   // One-cycle registered pixel lookup result.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hitR   <= 1'b0;
         idOutR <= EMPTY_ID;
         xOutR  <= {SIZE_LOG2{1'b0}};
         yOutR  <= {SIZE_LOG2{1'b0}};
      end else begin
         hitR   <= pixHit;
         idOutR <= pixId;
         xOutR  <= pixXOff;
         yOutR  <= pixYOff;
      end
   end

   assign bus.hit         = hitR;
   assign bus.spriteIDOut = idOutR;
   assign bus.sPosXOut    = xOutR;
   assign bus.sPosYOut    = yOutR;
   assign bus.overflow    = activeOvf;
   assign bus.scan_busy   = scanBusy;

endmodule

// File: tb/tb_sprite_line_mapper.sv
// Self-checking bench for sprite_line_mapper: table-driven pixel vectors fed
// through an expected-result queue, plus hand-written overflow, early
// line_start and mid-scan reset sequences.
module tb_sprite_line_mapper;
   import sprite_pkg::*;

   logic Clk = 1'b0;
   logic Reset;
   always #10 Clk = ~Clk;

   sprite_line_mapper_if #(.NUM_SPRITES(16)) bus ();

   sprite_line_mapper #(
      .NUM_SPRITES  (16),
      .MAX_PER_LINE (8)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   typedef struct {
      logic [9:0] x;
      logic       h;
      logic [3:0] id;
      logic [4:0] xo;
      logic [4:0] yo;
   } pixVec_t;

   pixVec_t vecs[$];
   pixVec_t expQ[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clearSprites();
      bus.SpriteID = {64{1'b1}};
      bus.PosX     = {160{1'b0}};
      bus.PosY     = {160{1'b0}};
   endtask

   task automatic setSprite(input int slot, input logic [3:0] id, input logic [9:0] x, input logic [9:0] y);
      bus.SpriteID[slot*4 +: 4]  = id;
      bus.PosX[slot*10 +: 10]    = x;
      bus.PosY[slot*10 +: 10]    = y;
   endtask

   task automatic pulseLine(input logic [9:0] y);
      bus.line_y     = y;
      bus.line_start = 1'b1;
      @(posedge Clk);
      #1;
      bus.line_start = 1'b0;
   endtask

   // Scan line y to completion, then swap it in as the active list.
   task automatic fullLine(input logic [9:0] y);
      pulseLine(y);
      check("busy_after_start", 32'(bus.scan_busy), 32'd1);
      repeat (17) @(posedge Clk);
      #1;
      check("busy_after_scan", 32'(bus.scan_busy), 32'd0);
      pulseLine(y);
   endtask

   task automatic addVec(input logic [9:0] x, input logic h, input logic [3:0] id,
                         input logic [4:0] xo, input logic [4:0] yo);
      pixVec_t v;
      v.x = x; v.h = h; v.id = id; v.xo = xo; v.yo = yo;
      vecs.push_back(v);
   endtask

   // Drive each queued vector, expect its result on the output one clock later.
   task automatic runVecs(input string name);
      pixVec_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         bus.DrawX = vecs[i].x;
         expQ.push_back(vecs[i]);
         @(posedge Clk);
         #1;
         e = expQ.pop_front();
         checks++;
         if (bus.hit !== e.h || bus.spriteIDOut !== e.id ||
             bus.sPosXOut !== e.xo || bus.sPosYOut !== e.yo) begin
            failures++;
            $display("FAIL %s x=%0d actual hit=%0b id=%0h xo=%0d yo=%0d required hit=%0b id=%0h xo=%0d yo=%0d",
                     name, e.x, bus.hit, bus.spriteIDOut, bus.sPosXOut, bus.sPosYOut,
                     e.h, e.id, e.xo, e.yo);
         end
      end
      vecs.delete();
   endtask

   task automatic checkIdleOutputs(input string name);
      check({name, "_hit"}, 32'(bus.hit), 32'd0);
      check({name, "_id"}, 32'(bus.spriteIDOut), 32'hf);
      check({name, "_xo"}, 32'(bus.sPosXOut), 32'd0);
      check({name, "_yo"}, 32'(bus.sPosYOut), 32'd0);
      check({name, "_ovf"}, 32'(bus.overflow), 32'd0);
      check({name, "_busy"}, 32'(bus.scan_busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset          = 1'b1;
      bus.line_start = 1'b0;
      bus.line_y     = 10'd0;
      bus.DrawX      = 10'd0;
      clearSprites();
      repeat (3) @(posedge Clk);
      #1;
      checkIdleOutputs("reset");
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      checkIdleOutputs("post_reset");

      // Single sprite at (512,512), first row of the sprite.
      setSprite(0, 4'd5, 10'd512, 10'd512);
      fullLine(10'd512);
      check("single_ovf", 32'(bus.overflow), 32'd0);
      addVec(10'd511, 1'b0, 4'hf, 5'd0, 5'd0);
      for (int x = 512; x <= 517; x++) addVec(10'(x), 1'b1, 4'd5, 5'(x - 512), 5'd0);
      runVecs("single");

      // Last row and last column of the same sprite, then just outside.
      fullLine(10'd543);
      addVec(10'd512, 1'b1, 4'd5, 5'd0, 5'd31);
      addVec(10'd543, 1'b1, 4'd5, 5'd31, 5'd31);
      addVec(10'd544, 1'b0, 4'hf, 5'd0, 5'd0);
      runVecs("edge");
      fullLine(10'd544);
      addVec(10'd520, 1'b0, 4'hf, 5'd0, 5'd0);
      runVecs("below");
      fullLine(10'd511);
      addVec(10'd520, 1'b0, 4'hf, 5'd0, 5'd0);
      runVecs("above");

      // Overlapping sprites: lower slot wins.
      clearSprites();
      setSprite(2, 4'd3, 10'd100, 10'd200);
      setSprite(7, 4'd9, 10'd110, 10'd200);
      fullLine(10'd210);
      addVec(10'd99,  1'b0, 4'hf, 5'd0,  5'd0);
      addVec(10'd110, 1'b1, 4'd3, 5'd10, 5'd10);
      addVec(10'd115, 1'b1, 4'd3, 5'd15, 5'd10);
      addVec(10'd135, 1'b1, 4'd9, 5'd25, 5'd10);
      addVec(10'd141, 1'b1, 4'd9, 5'd31, 5'd10);
      addVec(10'd142, 1'b0, 4'hf, 5'd0,  5'd0);
      runVecs("priority");

      // Ten sprites on one line: only the first eight are kept.
      clearSprites();
      for (int s = 0; s < 10; s++) setSprite(s, 4'(s), 10'(s * 40), 10'd300);
      fullLine(10'd300);
      check("ovf_set", 32'(bus.overflow), 32'd1);
      for (int s = 0; s < 10; s++) begin
         if (s < 8) addVec(10'(s * 40 + 3), 1'b1, 4'(s), 5'd3, 5'd0);
         else       addVec(10'(s * 40 + 3), 1'b0, 4'hf, 5'd0, 5'd0);
      end
      runVecs("overflow");
      fullLine(10'd0);
      check("ovf_clear", 32'(bus.overflow), 32'd0);

      // Early line_start five cycles into the scan: slots 0..3 only.
      pulseLine(10'd300);
      repeat (4) @(posedge Clk);
      #1;
      pulseLine(10'd300);
      check("early_busy", 32'(bus.scan_busy), 32'd1);
      check("early_ovf", 32'(bus.overflow), 32'd1);
      for (int s = 0; s < 6; s++) begin
         if (s < 4) addVec(10'(s * 40 + 3), 1'b1, 4'(s), 5'd3, 5'd0);
         else       addVec(10'(s * 40 + 3), 1'b0, 4'hf, 5'd0, 5'd0);
      end
      runVecs("early");

      // Reset in the middle of a scan while a sprite is being hit.
      fullLine(10'd300);
      bus.DrawX = 10'd3;
      @(posedge Clk);
      #1;
      check("pre_reset_hit", 32'(bus.hit), 32'd1);
      pulseLine(10'd300);
      repeat (2) @(posedge Clk);
      #5;
      Reset = 1'b1;
      #1;
      checkIdleOutputs("async_reset");
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      check("after_reset_hit", 32'(bus.hit), 32'd0);
      pulseLine(10'd300);
      repeat (17) @(posedge Clk);
      #1;
      check("one_swap_hit", 32'(bus.hit), 32'd0);
      pulseLine(10'd300);
      check("swap_edge_hit", 32'(bus.hit), 32'd0);
      @(posedge Clk);
      #1;
      check("two_swap_hit", 32'(bus.hit), 32'd1);
      check("two_swap_id", 32'(bus.spriteIDOut), 32'd0);
      check("two_swap_xo", 32'(bus.sPosXOut), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_line_mapper.md
Name: sprite_line_mapper

Overview:
- Parametrised successor to the combinational sprite mapper. Maps the current VGA pixel (DrawX, DrawY) to the highest-priority sprite covering it, plus the pixel offset inside that sprite.
- During each scanline it scans all sprite slots, one per clock, and builds a list of the sprites visible on the line named by line_y.
- The list is double-buffered and swapped on line_start, so pixel lookup uses only MAX_PER_LINE comparators.
- Sits between the game-state sprite registers and the sprite ROM/palette stage in the color mapper path.

Parameters:
- NUM_SPRITES, 16, number of sprite slots scanned.
- MAX_PER_LINE, 8, maximum sprites retained per scanline.
- COORD_W, 10, width of DrawX/DrawY/PosX/PosY.
- ID_W, 4, sprite ID width; the all-ones ID means the slot is empty.
- SIZE_LOG2, 5, sprite edge is 2**SIZE_LOG2 pixels (32).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- line_start  in  1  one-cycle pulse at the start of horizontal blank.
- line_y  in  COORD_W  scanline the new scan targets (the next displayed line).
- DrawX  in  COORD_W  current pixel X.
- PosX  in  NUM_SPRITES*COORD_W  packed sprite X positions; slot 0 is in the LSBs.
- PosY  in  NUM_SPRITES*COORD_W  packed sprite Y positions.
- SpriteID  in  NUM_SPRITES*ID_W  packed sprite IDs.
- spriteIDOut  out  ID_W  ID of the winning sprite, or all-ones if none.
- sPosXOut  out  SIZE_LOG2  X offset inside the winning sprite.
- sPosYOut  out  SIZE_LOG2  Y offset inside the winning sprite.
- hit  out  1  a sprite covers the pixel.
- overflow  out  1  the active line dropped sprites (more than MAX_PER_LINE were visible).
- scan_busy  out  1  a scan is in progress.

Behaviour:
- Reset, applied asynchronously:
  - FSM goes to IDLE; both lists are empty (count 0).
  - spriteIDOut = all-ones; sPosXOut = sPosYOut = 0; hit = 0; overflow = 0; scan_busy = 0.
- FSM states and transitions:
  - IDLE: on line_start, go to SCAN.
  - SCAN: scans slot i on cycle i+1 after line_start, for NUM_SPRITES cycles, then goes to DONE.
  - DONE: on line_start, go to SCAN.
- line_start, in any state:
  - The active list takes the previous scan list and that scan's overflow flag.
  - The scan list clears, line_y is latched into ly, the slot index resets to 0, and the FSM enters SCAN.
- line_start arriving during SCAN: the partial list is swapped in as-is, overflow is forced to 1 for that line, and the scan restarts.
- Slot selection during scan (ly = latched line_y):
  - Slot i is selected when SpriteID[i] != all-ones and PosY[i] <= ly < PosY[i] + 2**SIZE_LOG2.
  - The comparison uses COORD_W+1 bits, so there is no wrap at the top of the coordinate range.
- Selected slots append in ascending slot order, storing PosX, ID and (ly - PosY) truncated to SIZE_LOG2 bits.
- Append past MAX_PER_LINE entries: the entry is discarded and the scan overflow flag is set.
- Pixel stage, over the active list:
  - Entry k matches when PosX_k <= DrawX < PosX_k + 2**SIZE_LOG2 (COORD_W+1-bit compare).
  - The lowest k, i.e. the lowest slot number, wins.
  - Outputs are registered with latency 1 cycle from DrawX.
  - On a match: hit = 1, spriteIDOut = ID_k, sPosXOut = DrawX - PosX_k (low SIZE_LOG2 bits), sPosYOut = stored Y offset.
  - With no match: hit = 0, spriteIDOut = all-ones, offsets = 0.
- The PosX/PosY/SpriteID inputs are sampled only at scan time. Changes mid-line take effect on the next swap.
- scan_busy = 1 exactly while the FSM is in SCAN.

Decomposition:
- Package sprite_pkg holds:
  - typedef line_entry_t {PosX, ID, yoff}
  - the EMPTY_ID constant
  - the state enum {IDLE, SCAN, DONE}
  - a function in_range(pos, coord, size_log2)
- One sub-module, sprite_pixel_select: the combinational priority match over the active list. Its outputs are registered in the parent.

Test Plan:
- Single sprite, ID 5, at (512, 512), all other slots empty.
  - Pulse line_start with line_y = 512, wait 17 cycles, pulse line_start again.
  - Sweep DrawX 511..517: hit is 0 at 511, then 1 for 512..517 one cycle later, with sPosXOut = 0..5 and sPosYOut = 0.
- Edge and Y-offset check, same sprite, line_y = 543:
  - Swap in; sPosYOut = 31; DrawX 543 -> hit with sPosXOut = 31; DrawX 544 -> hit = 0, spriteIDOut = 4'hf.
- Priority: slot 2 (ID 3) at X 100 and slot 7 (ID 9) at X 110, same Y.
  - DrawX 115 -> ID 3, sPosXOut = 15; DrawX 135 -> ID 9, sPosXOut = 25.
- Overflow: 10 sprites with IDs 0..9 on the same line.
  - After the swap, overflow = 1; slots 8 and 9 never produce a hit; slots 0..7 do.
- Early line_start: second pulse 5 cycles after the first.
  - Only slots 0..3 are listed, overflow = 1, scan_busy stays 1.
- Reset mid-scan: Reset asserted during SCAN.
  - All outputs go immediately to their reset values, scan_busy = 0, and hit stays 0 until two completed line_starts.
